i2c_tx_fifo: RTL

I2C_TX_FIFO -- requirements
Module: i2c_tx_fifo

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_fifo_ram.sv | 26 ++
 rtl/i2c_tx_fifo.sv | 113 +++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: TX command word layout and FIFO sizing defaults.
package i2c_pkg;

    localparam int unsigned TX_WORD_W     = 10;
    localparam int unsigned STOP_BIT      = 9;
    localparam int unsigned START_BIT     = 8;
    localparam int unsigned DATA_MSB      = 7;
    localparam int unsigned TX_FIFO_DEPTH = 16;
    localparam int unsigned TX_FIFO_AW    = 4;

    // Command word as written by the register interface.
    typedef struct packed {
        logic       stop;
        logic       start;
        logic [7:0] data;
    } tx_word_t;

    // A start word with data[0] set carries a read byte count instead of an address.
    function automatic logic is_read_count(input tx_word_t w);
        return w.start & w.data[0];
    endfunction

endpackage

// File: rtl/i2c_fifo_ram.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module i2c_fifo_ram #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_tx_fifo.sv
// I2C transmit command FIFO: first-word-fall-through, occupancy counter, sticky overflow/underflow.
module i2c_tx_fifo
    import i2c_pkg::*;
#(
    parameter int unsigned DEPTH = TX_FIFO_DEPTH,
    parameter int unsigned AW    = TX_FIFO_AW
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 tx_fifo_flush,
    input  logic                 tx_fifo_wr,
    input  logic [TX_WORD_W-1:0] tx_fifo_din,
    output logic                 tx_fifo_full,
    input  logic                 tx_fifo_rd,
    output logic [TX_WORD_W-1:0] tx_fifo_dout,
    output logic                 tx_fifo_empty,
    output logic [AW:0]          tx_fifo_occ,
    output logic                 tx_fifo_ovf,
    output logic                 tx_fifo_udf,
    input  logic                 ovf_udf_clr
);

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   occ;
    logic          ovf;
    logic          udf;

    logic wr_ok;
    logic rd_ok;
    logic wr_drop;
    logic rd_drop;
    logic ram_we;

    assign tx_fifo_full  = (occ == (AW+1)'(DEPTH));
    assign tx_fifo_empty = (occ == '0);
    assign tx_fifo_occ   = occ;
    assign tx_fifo_ovf   = ovf;
    assign tx_fifo_udf   = udf;

    // A full FIFO still takes a write when the same cycle pops the head.
    always_comb begin
        wr_ok   = 1'b0;
        rd_ok   = 1'b0;
        wr_drop = 1'b0;
        rd_drop = 1'b0;
        if (!tx_fifo_flush) begin
            rd_ok   = tx_fifo_rd & ~tx_fifo_empty;
            rd_drop = tx_fifo_rd &  tx_fifo_empty;
            wr_ok   = tx_fifo_wr & (~tx_fifo_full | tx_fifo_rd);
            wr_drop = tx_fifo_wr &  tx_fifo_full & ~tx_fifo_rd;
        end
    end

    assign ram_we = wr_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else if (tx_fifo_flush) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else begin
            if (wr_ok) begin
                wp <= wp + AW'(1);
            end
            if (rd_ok) begin
                rp <= rp + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Sticky error flags; a new event in the clearing cycle wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr_drop) begin
                ovf <= 1'b1;
            end else if (ovf_udf_clr) begin
                ovf <= 1'b0;
            end
            if (rd_drop) begin
                udf <= 1'b1;
            end else if (ovf_udf_clr) begin
                udf <= 1'b0;
            end
        end
    end

    i2c_fifo_ram #(
        .WIDTH (TX_WORD_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wp),
        .wdata (tx_fifo_din),
        .raddr (rp),
        .rdata (tx_fifo_dout)
    );

endmodule
